// File: rtl/ps2_jump_engine_pkg.sv
// ----------------------------------------------------------------------------
// ps2_jump_engine_pkg
//   Shared definitions for the PS/2 jump engine: scan-code constants, default
//   key codes, key_held bit positions, and the decoder / physics state enums.
//   Also a helper that turns a clock rate and an update rate into a tick
//   period in clock cycles.
// ----------------------------------------------------------------------------
package ps2_jump_engine_pkg;

    // PS/2 set-2 prefix bytes.
    localparam logic [7:0] SCAN_BREAK  = 8'hF0;
    localparam logic [7:0] SCAN_EXTEND = 8'hE0;

    // Default make codes for the two keys the engine tracks.
    localparam logic [7:0] KEY_JUMP_DEFAULT = 8'h1C;
    localparam logic [7:0] KEY_DUCK_DEFAULT = 8'h1B;

    // Bit positions inside key_held.
    localparam int KEY_JUMP = 0;
    localparam int KEY_DUCK = 1;

    // Scan decoder states: plain, after F0, after E0, after E0 F0.
    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_BRK,
        DEC_EXT,
        DEC_EXT_BRK
    } dec_state_t;

    // Physics states: resting on the ground or airborne.
    typedef enum logic {
        PHY_GND,
        PHY_AIR
    } phy_state_t;

    // Clock cycles between physics ticks; never less than one so a very
    // fast tick rate degenerates to "every cycle" rather than to zero.
    function automatic int tick_cycles(input int clock_hz, input int ticks_per_sec);
        int cycles;
        cycles = (ticks_per_sec > 0) ? (clock_hz / ticks_per_sec) : 1;
        return (cycles < 1) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/ps2_key_tracker.sv
// ----------------------------------------------------------------------------
// ps2_key_tracker
//   Decodes a stream of PS/2 set-2 bytes into a held/released state for the
//   jump and duck keys. Break (F0) sequences release a key, plain make codes
//   press it, and anything behind an E0 prefix is consumed without touching
//   the key state. Typematic repeats of a make code simply re-set a bit that
//   is already set.
//
// Ports
//   CLOCK_50     in   clock
//   resetn       in   asynchronous active-low reset
//   ps2_data     in   received byte
//   ps2_data_en  in   one-cycle strobe qualifying ps2_data
//   key_held     out  bit0 jump held, bit1 duck held
// ----------------------------------------------------------------------------
module ps2_key_tracker
    import ps2_jump_engine_pkg::*;
#(
    parameter logic [7:0] JUMP_CODE = KEY_JUMP_DEFAULT,
    parameter logic [7:0] DUCK_CODE = KEY_DUCK_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] ps2_data,
    input  logic       ps2_data_en,
    output logic [1:0] key_held
);

    dec_state_t dec_state;

    // NOTE: every register here is updated with <= so all state moves on the
    // same edge from the same old values, regardless of statement order.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            dec_state <= DEC_IDLE;
            key_held  <= 2'b00;
        end else if (ps2_data_en) begin
            case (dec_state)
                DEC_IDLE: begin
                    if (ps2_data == SCAN_BREAK) begin
                        dec_state <= DEC_BRK;
                    end else if (ps2_data == SCAN_EXTEND) begin
                        dec_state <= DEC_EXT;
                    end else begin
                        if (ps2_data == JUMP_CODE) key_held[KEY_JUMP] <= 1'b1;
                        if (ps2_data == DUCK_CODE) key_held[KEY_DUCK] <= 1'b1;
                    end
                end
                DEC_BRK: begin
                    // The byte after F0 always completes the sequence.
                    if (ps2_data == JUMP_CODE) key_held[KEY_JUMP] <= 1'b0;
                    if (ps2_data == DUCK_CODE) key_held[KEY_DUCK] <= 1'b0;
                    dec_state <= DEC_IDLE;
                end
                DEC_EXT: begin
                    // Extended keys never reach key_held; only track the
                    // framing so the trailing code is not taken as a make.
                    dec_state <= (ps2_data == SCAN_BREAK) ? DEC_EXT_BRK : DEC_IDLE;
                end
                DEC_EXT_BRK: begin
                    dec_state <= DEC_IDLE;
                end
                default: begin
                    dec_state <= DEC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ps2_jump_engine.sv
// ----------------------------------------------------------------------------
// ps2_jump_engine
//   Keyboard-driven jump physics. A ps2_key_tracker turns PS/2 bytes into
//   jump/duck held flags. A fresh jump press while grounded and not ducking
//   launches the character; while airborne a tick generator advances a
//   simple ballistic model (height += velocity, velocity -= gravity, doubled
//   while duck is held) until the next position would be at or below the
//   ground, at which point the character lands with a one-cycle strobe.
//
// Ports
//   CLOCK_50     in   clock
//   resetn       in   asynchronous active-low reset
//   ps2_data     in   received PS/2 byte
//   ps2_data_en  in   one-cycle strobe qualifying ps2_data
//   height       out  unsigned current height
//   velocity     out  two's-complement current velocity
//   jumping      out  airborne
//   ducking      out  grounded with duck held
//   key_held     out  bit0 jump held, bit1 duck held
//   airtime      out  ticks in the current/last jump, saturating at 255
//   land_pulse   out  one-cycle strobe on landing
// ----------------------------------------------------------------------------
module ps2_jump_engine
    import ps2_jump_engine_pkg::*;
#(
    parameter int         CLOCK_FREQUENCY = 25000000,
    parameter int         TICKS_PER_SEC   = 4,
    parameter int         HEIGHT_W        = 16,
    parameter int         GROUND          = 10,
    parameter int         V0              = 50,
    parameter int         GRAVITY         = 1,
    parameter logic [7:0] JUMP_CODE       = KEY_JUMP_DEFAULT,
    parameter logic [7:0] DUCK_CODE       = KEY_DUCK_DEFAULT
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [7:0]          ps2_data,
    input  logic                ps2_data_en,
    output logic [HEIGHT_W-1:0] height,
    output logic [HEIGHT_W-1:0] velocity,
    output logic                jumping,
    output logic                ducking,
    output logic [1:0]          key_held,
    output logic [7:0]          airtime,
    output logic                land_pulse
);

    localparam int TICK_CYCLES = tick_cycles(CLOCK_FREQUENCY, TICKS_PER_SEC);
    localparam int CNT_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HW1         = HEIGHT_W + 1;

    localparam logic [CNT_W-1:0]           TICK_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [HEIGHT_W-1:0]        GROUND_H  = HEIGHT_W'(GROUND);
    localparam logic signed [HEIGHT_W:0]   GROUND_S  = HW1'(GROUND);
    localparam logic [HEIGHT_W-1:0]        V0_V      = HEIGHT_W'(V0);
    localparam logic [HEIGHT_W-1:0]        GRAV_1    = HEIGHT_W'(GRAVITY);
    localparam logic [HEIGHT_W-1:0]        GRAV_2    = HEIGHT_W'(2 * GRAVITY);

    // ------------------------------------------------------------------
    // Key decoding
    // ------------------------------------------------------------------
    logic [1:0] keys;

    ps2_key_tracker #(
        .JUMP_CODE (JUMP_CODE),
        .DUCK_CODE (DUCK_CODE)
    ) u_key_tracker (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .ps2_data    (ps2_data),
        .ps2_data_en (ps2_data_en),
        .key_held    (keys)
    );

    // ------------------------------------------------------------------
    // Launch arming and tick generation
    // ------------------------------------------------------------------
    phy_state_t             phy_state;
    logic [CNT_W-1:0]       tick_cnt;
    logic                   jump_prev;
    logic                   jump_rise;
    logic                   launch;
    logic                   tick;
    logic signed [HEIGHT_W:0] next_s;
    logic [HEIGHT_W-1:0]    grav_step;

    // Only a 0->1 transition of the jump key arms a launch. An edge that
    // happens while airborne, while ducking, or on the landing cycle is
    // simply lost, so holding the key never relaunches and a fresh press is
    // needed after landing.
    assign jump_rise = keys[KEY_JUMP] & ~jump_prev;
    assign launch    = (phy_state == PHY_GND) && jump_rise && !keys[KEY_DUCK];
    assign tick      = (phy_state == PHY_AIR) && (tick_cnt == TICK_LAST);

    // Next position, evaluated one bit wider so a falling character near
    // zero cannot wrap to a large unsigned height.
    assign next_s    = $signed({1'b0, height}) + $signed({velocity[HEIGHT_W-1], velocity});
    assign grav_step = keys[KEY_DUCK] ? GRAV_2 : GRAV_1;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
        end else if (launch || phy_state != PHY_AIR || tick) begin
            // Restart the period on launch so the first tick is a full
            // period after lift-off; idle at zero on the ground.
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Physics FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            phy_state  <= PHY_GND;
            height     <= GROUND_H;
            velocity   <= '0;
            airtime    <= '0;
            land_pulse <= 1'b0;
            jump_prev  <= 1'b0;
        end else begin
            jump_prev  <= keys[KEY_JUMP];
            land_pulse <= 1'b0;
            case (phy_state)
                PHY_GND: begin
                    if (launch) begin
                        phy_state <= PHY_AIR;
                        height    <= GROUND_H;
                        velocity  <= V0_V;
                        airtime   <= '0;
                    end
                end
                PHY_AIR: begin
                    if (tick) begin
                        if (next_s <= GROUND_S) begin
                            phy_state  <= PHY_GND;
                            height     <= GROUND_H;
                            velocity   <= '0;
                            land_pulse <= 1'b1;
                        end else begin
                            height   <= next_s[HEIGHT_W-1:0];
                            velocity <= velocity - grav_step;
                            if (airtime != 8'hFF) airtime <= airtime + 8'd1;
                        end
                    end
                end
                default: begin
                    phy_state <= PHY_GND;
                end
            endcase
        end
    end

    assign jumping  = (phy_state == PHY_AIR);
    assign ducking  = keys[KEY_DUCK] && (phy_state == PHY_GND);
    assign key_held = keys;

endmodule

// File: tb/tb_ps2_jump_engine.sv
// ----------------------------------------------------------------------------
// tb_ps2_jump_engine
//   Directed scenarios plus randomized PS/2 traffic against a behavioural
//   model of the jump engine. The model decodes bytes as whole sequences
//   kept in a queue and advances physics with integer arithmetic, counting
//   cycles since launch to place ticks.
// ----------------------------------------------------------------------------
module tb_ps2_jump_engine;

    localparam int CLK_HZ  = 8;
    localparam int TPS     = 4;
    localparam int HW      = 16;
    localparam int GND_H   = 10;
    localparam int LAUNCH  = 4;
    localparam int GRAV    = 1;
    localparam int TICK_N  = CLK_HZ / TPS;

    localparam logic [7:0] B_JUMP = 8'h1C;
    localparam logic [7:0] B_DUCK = 8'h1B;
    localparam logic [7:0] B_BRK  = 8'hF0;
    localparam logic [7:0] B_EXT  = 8'hE0;

    logic          CLOCK_50;
    logic          resetn;
    logic [7:0]    ps2_data;
    logic          ps2_data_en;
    logic [HW-1:0] height;
    logic [HW-1:0] velocity;
    logic          jumping;
    logic          ducking;
    logic [1:0]    key_held;
    logic [7:0]    airtime;
    logic          land_pulse;

    int total = 0;
    int bad   = 0;

    ps2_jump_engine #(
        .CLOCK_FREQUENCY (CLK_HZ),
        .TICKS_PER_SEC   (TPS),
        .HEIGHT_W        (HW),
        .GROUND          (GND_H),
        .V0              (LAUNCH),
        .GRAVITY         (GRAV),
        .JUMP_CODE       (B_JUMP),
        .DUCK_CODE       (B_DUCK)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .ps2_data    (ps2_data),
        .ps2_data_en (ps2_data_en),
        .height      (height),
        .velocity    (velocity),
        .jumping     (jumping),
        .ducking     (ducking),
        .key_held    (key_held),
        .airtime     (airtime),
        .land_pulse  (land_pulse)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic signed [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int m_kj = 0, m_kd = 0;      // jump / duck held
    int m_prev = 0;              // jump held one cycle ago
    int m_air = 0;
    int m_h = GND_H, m_v = 0, m_at = 0, m_land = 0;
    int m_k = 0;                 // cycles since launch
    logic [7:0] m_pend[$];       // bytes of the sequence being received
    int m_tick_h[$];             // height after each tick of the current jump

    task automatic model_reset();
        m_kj = 0; m_kd = 0; m_prev = 0; m_air = 0;
        m_h = GND_H; m_v = 0; m_at = 0; m_land = 0; m_k = 0;
        m_pend.delete();
    endtask

    task automatic model_step(input logic en, input logic [7:0] b);
        int nj, nd, s;
        bit more;
        nj = m_kj;
        nd = m_kd;
        if (en) begin
            m_pend.push_back(b);
            more = (m_pend.size() == 1 && (b == B_BRK || b == B_EXT)) ||
                   (m_pend.size() == 2 && m_pend[0] == B_EXT && b == B_BRK);
            if (!more) begin
                if (m_pend.size() == 1) begin
                    if (b == B_JUMP) nj = 1;
                    if (b == B_DUCK) nd = 1;
                end else if (m_pend.size() == 2 && m_pend[0] == B_BRK) begin
                    if (b == B_JUMP) nj = 0;
                    if (b == B_DUCK) nd = 0;
                end
                m_pend.delete();
            end
        end
        m_land = 0;
        if (!m_air) begin
            if (m_kj == 1 && m_prev == 0 && m_kd == 0) begin
                m_air = 1; m_h = GND_H; m_v = LAUNCH; m_at = 0; m_k = 0;
                m_tick_h.delete();
            end
        end else begin
            m_k++;
            if (m_k % TICK_N == 0) begin
                s = m_h + m_v;
                if (s <= GND_H) begin
                    m_h = GND_H; m_v = 0; m_land = 1; m_air = 0;
                end else begin
                    m_h = s;
                    m_v = m_v - (m_kd ? 2 * GRAV : GRAV);
                    if (m_at < 255) m_at++;
                end
                m_tick_h.push_back(m_h);
            end
        end
        m_prev = m_kj;
        m_kj = nj;
        m_kd = nd;
    endtask

    always @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) model_reset();
        else         model_step(ps2_data_en, ps2_data);
    end

    // One compare process, on the falling edge when everything has settled.
    always @(negedge CLOCK_50) begin
        check("height",     height,            m_h);
        check("velocity",   $signed(velocity), m_v);
        check("jumping",    jumping,           m_air);
        check("ducking",    ducking,           (m_kd != 0 && m_air == 0) ? 1 : 0);
        check("key_held",   key_held,          m_kd * 2 + m_kj);
        check("airtime",    airtime,           m_at);
        check("land_pulse", land_pulse,        m_land);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // NOTE: inputs change with blocking assignments 1 time unit after the
    // rising edge so neither the DUT nor the model can race on them.
    task automatic send_byte(input logic [7:0] b);
        @(posedge CLOCK_50);
        #1;
        ps2_data    = b;
        ps2_data_en = 1'b1;
        @(posedge CLOCK_50);
        #1;
        ps2_data_en = 1'b0;
        ps2_data    = $urandom_range(0, 255);
    endtask

    task automatic wait_land(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLOCK_50);
            if (land_pulse) begin
                seen = 1;
                break;
            end
        end
        check("landed_in_time", seen, 1);
    endtask

    task automatic pulse_reset();
        @(posedge CLOCK_50);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_height",   height,            GND_H);
        check("rst_velocity", $signed(velocity), 0);
        check("rst_jumping",  jumping,           0);
        check("rst_key_held", key_held,          0);
        check("rst_airtime",  airtime,           0);
        check("rst_land",     land_pulse,        0);
        cycles(2);
        @(posedge CLOCK_50);
        #1;
        resetn = 1'b1;
    endtask

    int exp_h[9] = '{14, 17, 19, 20, 20, 19, 17, 14, 10};
    int exp_duck_h[7] = '{14, 17, 19, 19, 17, 13, 10};

    initial begin
        bit found;
        int r;
        logic [7:0] b;

        resetn      = 1'b0;
        ps2_data    = 8'h00;
        ps2_data_en = 1'b0;
        cycles(3);
        check("init_height",  height,   GND_H);
        check("init_jumping", jumping,  0);
        check("init_keys",    key_held, 0);
        @(posedge CLOCK_50);
        #1;
        resetn = 1'b1;

        // Make, repeat make, break; launch on the first make.
        send_byte(B_JUMP);
        cycles(1);
        check("make_sets_jump", key_held, 1);
        cycles(1);
        check("first_make_launches", jumping, 1);
        send_byte(B_JUMP);
        cycles(1);
        check("repeat_make_idempotent", key_held, 1);
        send_byte(B_BRK);
        send_byte(B_JUMP);
        cycles(1);
        check("break_clears_jump", key_held, 0);
        wait_land(100);
        check("land_height",  height,  GND_H);
        check("land_airtime", airtime, 8);
        check("model_tick_count", m_tick_h.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < m_tick_h.size()) check("model_tick_height", m_tick_h[i], exp_h[i]);
        cycles(3);

        // Extended codes never touch key_held.
        send_byte(B_EXT);
        send_byte(B_JUMP);
        send_byte(B_EXT);
        send_byte(B_BRK);
        send_byte(B_JUMP);
        cycles(3);
        check("ext_keys_untouched", key_held, 0);
        check("ext_no_launch",      jumping,  0);

        // Held through landing: no relaunch until released and re-pressed.
        send_byte(B_JUMP);
        cycles(2);
        wait_land(100);
        cycles(6);
        check("held_no_relaunch", jumping, 0);
        check("held_still_held",  key_held, 1);
        send_byte(B_BRK);
        send_byte(B_JUMP);
        send_byte(B_JUMP);
        cycles(2);
        check("repress_relaunches", jumping, 1);
        wait_land(100);
        send_byte(B_BRK);
        send_byte(B_JUMP);
        cycles(2);

        // Duck from tick 2 shortens the flight.
        send_byte(B_JUMP);
        cycles(2);
        cycles(3);
        send_byte(B_DUCK);
        wait_land(100);
        check("duck_tick_count", m_tick_h.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < m_tick_h.size()) check("duck_tick_height", m_tick_h[i], exp_duck_h[i]);
        check("duck_land_airtime", airtime, 6);
        cycles(1);
        check("ducking_grounded", ducking, 1);
        send_byte(B_BRK);
        send_byte(B_JUMP);
        send_byte(B_JUMP);
        cycles(4);
        check("duck_blocks_launch", jumping, 0);
        send_byte(B_BRK);
        send_byte(B_DUCK);
        cycles(3);
        check("lost_edge_no_launch", jumping, 0);
        send_byte(B_BRK);
        send_byte(B_JUMP);
        cycles(2);

        // Re-press swept across the landing cycle.
        for (int d = 4; d <= 16; d++) begin
            send_byte(B_JUMP);
            cycles(2);
            send_byte(B_BRK);
            send_byte(B_JUMP);
            cycles(d);
            send_byte(B_JUMP);
            cycles(3);
            if (jumping) wait_land(100);
            send_byte(B_BRK);
            send_byte(B_JUMP);
            cycles(3);
        end

        // Reset mid-jump with an E0 prefix pending.
        send_byte(B_JUMP);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            if (height == 19) begin
                found = 1;
                break;
            end
        end
        check("reached_tick3", found, 1);
        send_byte(B_EXT);
        pulse_reset();
        send_byte(B_JUMP);
        cycles(1);
        check("prefix_discarded", key_held, 1);
        cycles(1);
        check("post_reset_launch", jumping, 1);
        wait_land(100);
        pulse_reset();
        send_byte(B_BRK);
        send_byte(B_JUMP);
        cycles(1);
        check("f0_enters_brk", key_held, 0);
        send_byte(B_JUMP);
        cycles(1);
        check("brk_returns_idle", key_held, 1);
        wait_land(100);
        send_byte(B_BRK);
        send_byte(B_JUMP);

        // Random traffic.
        for (int n = 0; n < 350; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: b = B_JUMP;
                3, 4:    b = B_DUCK;
                5, 6:    b = B_BRK;
                7:       b = B_EXT;
                default: b = 8'($urandom_range(0, 255));
            endcase
            if (r != 9) send_byte(b);
            cycles($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) cycles($urandom_range(15, 30));
            if ($urandom_range(0, 99) == 0) begin
                @(posedge CLOCK_50);
                #3;
                resetn = 1'b0;
                cycles(2);
                @(posedge CLOCK_50);
                #1;
                resetn = 1'b1;
            end
        end
        cycles(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
